// File: rtl/round_timer.sv
// round_timer
// -----------
// Countdown timer for a game round. The remaining time is held purely as two
// BCD digits. The count decrements on each 1 Hz tick while running. Start and
// pause come from push-buttons and act on their rising edges only. When the
// count reaches 00 the round is marked expired and a single-cycle pulse is
// emitted. All outputs come straight from flops.
//
// Optional feature: define ROUND_TIMER_PENALTY_EN to enable penalties. When it
// is defined, each penalty pulse accepted while running removes PENALTY_SECS
// and pulses sub for one cycle. When it is undefined, penalty is ignored and
// sub is tied low.
//
// Parameters
//   START_SECS    round length in seconds (1..99)
//   PENALTY_SECS  seconds removed per penalty (1..9)
// Ports
//   clock         single clock, rising edge
//   reset         synchronous active-high reset
//   start         push-button level, rising edge (re)starts the round
//   pause         push-button level, rising edge toggles RUN/PAUSED
//   tick          one-cycle 1 Hz pulse from the upstream divider
//   penalty       one-cycle player-fault pulse
//   enable        upstream divider enable, high only while running
//   sub           one-cycle request to shorten the divider period
//   secs_tens     BCD tens digit of remaining seconds
//   secs_ones     BCD ones digit of remaining seconds
//   running       high while counting
//   expired       high while the round is over
//   expire_pulse  one-cycle pulse at the end of a round
module round_timer #(
    parameter int START_SECS   = 60,
    parameter int PENALTY_SECS = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    input  logic       penalty,
    output logic       enable,
    output logic       sub,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECS % 10);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       startPrev_q, pausePrev_q;
    logic       enable_q, running_q, expired_q, expirePulse_q;
    logic       expirePulse_d;
    logic       startEdge, pauseEdge;

    logic [4:0] decAmount;
    logic [4:0] decTens, decOnes, subOnes, needTens;
    logic       borrow;
    logic [3:0] newTens, newOnes;

    assign startEdge = start & ~startPrev_q;
    assign pauseEdge = pause & ~pausePrev_q;

`ifdef ROUND_TIMER_PENALTY_EN
    logic sub_q, sub_d;
    assign decAmount = {4'd0, tick} + (penalty ? 5'(PENALTY_SECS) : 5'd0);
    assign sub       = sub_q;
`else
    logic unusedPenalty;
    localparam int unusedPenaltySecs = PENALTY_SECS;
    assign unusedPenalty = penalty;
    assign decAmount     = {4'd0, tick};
    assign sub           = 1'b0;
`endif

    // BCD subtraction of decAmount (0..10) done digit by digit with a borrow,
    // saturating at 00 instead of wrapping.
    always_comb begin
        decTens  = (decAmount >= 5'd10) ? 5'd1 : 5'd0;
        decOnes  = (decAmount >= 5'd10) ? (decAmount - 5'd10) : decAmount;
        subOnes  = 5'd0;
        borrow   = 1'b0;
        newTens  = 4'd0;
        newOnes  = 4'd0;
        if ({1'b0, ones_q} >= decOnes) begin
            subOnes = {1'b0, ones_q} - decOnes;
            borrow  = 1'b0;
        end else begin
            subOnes = {1'b0, ones_q} + 5'd10 - decOnes;
            borrow  = 1'b1;
        end
        needTens = decTens + {4'd0, borrow};
        if ({1'b0, tens_q} >= needTens) begin
            newTens = tens_q - needTens[3:0];
            newOnes = subOnes[3:0];
        end
    end

    // Next-state logic. A start edge beats everything; in RUN a pause edge
    // takes the cycle and any tick/penalty arriving with it is dropped.
    always_comb begin
        state_d       = state_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        expirePulse_d = 1'b0;
`ifdef ROUND_TIMER_PENALTY_EN
        sub_d         = 1'b0;
`endif
        if (startEdge) begin
            state_d = RUN;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
        end else begin
            case (state_q)
                RUN: begin
                    if (pauseEdge) begin
                        state_d = PAUSED;
                    end else begin
`ifdef ROUND_TIMER_PENALTY_EN
                        sub_d = penalty;
`endif
                        if (decAmount != 5'd0) begin
                            tens_d = newTens;
                            ones_d = newOnes;
                            if (newTens == 4'd0 && newOnes == 4'd0) begin
                                state_d       = EXPIRED;
                                expirePulse_d = 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (pauseEdge) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, count and output flags. Flags are derived from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            tens_q        <= START_TENS;
            ones_q        <= START_ONES;
            startPrev_q   <= 1'b0;
            pausePrev_q   <= 1'b0;
            enable_q      <= 1'b0;
            running_q     <= 1'b0;
            expired_q     <= 1'b0;
            expirePulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            startPrev_q   <= start;
            pausePrev_q   <= pause;
            enable_q      <= (state_d == RUN);
            running_q     <= (state_d == RUN);
            expired_q     <= (state_d == EXPIRED);
            expirePulse_q <= expirePulse_d;
        end
    end

`ifdef ROUND_TIMER_PENALTY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign enable       = enable_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expirePulse_q;
    assign secs_tens    = tens_q;
    assign secs_ones    = ones_q;

endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer
// --------------
// Drives round_timer with directed sequences followed by random button,
// tick and penalty activity, and compares every cycle against a reference
// model that keeps the remaining time as a plain integer number of seconds.
module tb_round_timer;

    localparam int START = 60;
    localparam int PEN   = 5;
`ifdef ROUND_TIMER_PENALTY_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic       clock = 1'b0;
    logic       reset, start, pause, tick, penalty;
    logic       enable, sub, running, expired, expire_pulse;
    logic [3:0] secs_tens, secs_ones;

    int  checks = 0;
    int  fails  = 0;

    int  mState, mCnt;
    bit  mPrevStart, mPrevPause, mPulse, mSub;

    round_timer #(.START_SECS(START), .PENALTY_SECS(PEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .tick         (tick),
        .penalty      (penalty),
        .enable       (enable),
        .sub          (sub),
        .secs_tens    (secs_tens),
        .secs_ones    (secs_ones),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs just applied.
    task automatic modelStep();
        bit se, pe;
        int dec;
        mPulse = 1'b0;
        mSub   = 1'b0;
        if (reset) begin
            mState     = M_IDLE;
            mCnt       = START;
            mPrevStart = 1'b0;
            mPrevPause = 1'b0;
        end else begin
            se = start && !mPrevStart;
            pe = pause && !mPrevPause;
            mPrevStart = start;
            mPrevPause = pause;
            if (se) begin
                mState = M_RUN;
                mCnt   = START;
            end else if (mState == M_RUN) begin
                if (pe) begin
                    mState = M_PAUSED;
                end else begin
                    dec  = (tick ? 1 : 0) + ((PEN_EN && penalty) ? PEN : 0);
                    mSub = PEN_EN && penalty;
                    if (dec > 0) begin
                        mCnt = (mCnt > dec) ? mCnt - dec : 0;
                        if (mCnt == 0) begin
                            mState = M_EXPIRED;
                            mPulse = 1'b1;
                        end
                    end
                end
            end else if (mState == M_PAUSED && pe) begin
                mState = M_RUN;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, and check all outputs.
    task automatic applyStimulus(input bit r, input bit s, input bit p,
                                 input bit t, input bit pen);
        logic [7:0] expFlags;
        reset   = r;
        start   = s;
        pause   = p;
        tick    = t;
        penalty = pen;
        @(posedge clock);
        modelStep();
        #1;
        expFlags = {3'b000, mState == M_RUN, mSub, mState == M_RUN,
                    mState == M_EXPIRED, mPulse};
        checkOutput("tens", {4'd0, secs_tens}, 8'(mCnt / 10));
        checkOutput("ones", {4'd0, secs_ones}, 8'(mCnt % 10));
        checkOutput("flags", {3'b000, enable, sub, running, expired, expire_pulse},
                    expFlags);
    endtask

    task automatic tickUntil(input int target);
        int guard = 0;
        while (mCnt > target && guard < 200) begin
            applyStimulus(0, 0, 0, 1, 0);
            guard++;
        end
        checkOutput("tick_budget", 8'(guard < 200), 8'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0; penalty = 1'b0;
        mState = M_IDLE; mCnt = START;
        mPrevStart = 1'b0; mPrevPause = 1'b0; mPulse = 1'b0; mSub = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("rst_digits", {secs_tens, secs_ones}, 8'h60);
        checkOutput("rst_flags", {3'b000, enable, sub, running, expired, expire_pulse}, 8'h00);

        // Start then three ticks
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("run3_digits", {secs_tens, secs_ones}, 8'h57);
        checkOutput("run3_flags", {6'd0, running, enable}, 8'h03);

        // Tens borrow and expiry
        tickUntil(10);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("borrow_digits", {secs_tens, secs_ones}, 8'h09);
        tickUntil(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("exp_digits", {secs_tens, secs_ones}, 8'h00);
        checkOutput("exp_flags", {6'd0, expired, expire_pulse}, 8'h03);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("exp_hold", {6'd0, expired, expire_pulse}, 8'h02);

        // Pause holds count and enable drops; second pause resumes
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        tickUntil(33);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 1, 1, 1);
        checkOutput("pause_digits", {secs_tens, secs_ones}, 8'h33);
        checkOutput("pause_enable", {7'd0, enable}, 8'h00);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("resume_digits", {secs_tens, secs_ones}, 8'h32);

        // Start and pause together: start wins
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("startwin_digits", {secs_tens, secs_ones}, 8'h60);
        checkOutput("startwin_run", {7'd0, running}, 8'h01);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-run overrides tick and penalty
        tickUntil(33);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("midrst_digits", {secs_tens, secs_ones}, 8'h60);
        checkOutput("midrst_flags", {3'b000, enable, sub, running, expired, expire_pulse}, 8'h00);

        // Penalty behaviour
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        tickUntil(20);
        applyStimulus(0, 0, 0, 1, 1);
`ifdef ROUND_TIMER_PENALTY_EN
        checkOutput("tickpen_digits", {secs_tens, secs_ones}, 8'h14);
        checkOutput("tickpen_sub", {7'd0, sub}, 8'h01);
`else
        checkOutput("tickpen_digits", {secs_tens, secs_ones}, 8'h19);
        checkOutput("tickpen_sub", {7'd0, sub}, 8'h00);
`endif
        tickUntil(3);
        applyStimulus(0, 0, 0, 0, 1);
`ifdef ROUND_TIMER_PENALTY_EN
        checkOutput("pensat_digits", {secs_tens, secs_ones}, 8'h00);
        checkOutput("pensat_flags", {5'd0, sub, expired, expire_pulse}, 8'h07);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pensat_subdrop", {7'd0, sub}, 8'h00);
`else
        checkOutput("pensat_digits", {secs_tens, secs_ones}, 8'h03);
        checkOutput("pensat_sub", {7'd0, sub}, 8'h00);
`endif

        // Random activity against the model
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 119) == 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
